// File: rtl/picc_tx_arbiter.sv
// Round-robin arbiter sharing one PICC-to-PCD encoder between REQ_COUNT requesters.
// Optional start timeout in WAIT_BUSY is enabled by defining PICC_TX_TIMEOUT_EN.
module picc_tx_arbiter #(
  parameter int unsigned REQ_COUNT     = 4,
  parameter int unsigned GUARD_CYCLES  = 16,
  parameter int unsigned START_TIMEOUT = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [REQ_COUNT-1:0]    req_valid_in,
  input  logic [40*REQ_COUNT-1:0] req_data_in,
  input  logic [3*REQ_COUNT-1:0]  req_bytes_in,
  output logic [REQ_COUNT-1:0]    req_ready_out,
  output logic [REQ_COUNT-1:0]    done_out,
  output logic                    err_out,
  output logic [39:0]             tx_data_out,
  output logic [2:0]              tx_num_bytes_out,
  output logic                    tx_trigger_out,
  input  logic                    tx_busy_in,
  output logic                    arb_busy_out
);

  localparam int unsigned IW   = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam int unsigned CMAX = (GUARD_CYCLES > START_TIMEOUT) ? GUARD_CYCLES : START_TIMEOUT;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GUARD} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          win_q, win_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [39:0]            tx_data_q, tx_data_d;
  logic [2:0]             tx_bytes_q, tx_bytes_d;
  logic [REQ_COUNT-1:0]   ready_q, ready_d;
  logic [REQ_COUNT-1:0]   done_q, done_d;
  logic                   err_q, err_d;
  logic                   trig_q, trig_d;

  logic                   found;
  logic [IW-1:0]          pick;
  logic [IW-1:0]          sel;
  logic [2:0]             pick_bytes;
  logic [39:0]            pick_data;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_bytes_d = tx_bytes_q;
    ready_d    = '0;
    done_d     = '0;
    err_d      = 1'b0;
    trig_d     = 1'b0;
    found      = 1'b0;
    pick       = '0;
    sel        = '0;

    for (int unsigned k = 0; k < REQ_COUNT; k++) begin
      sel = IW'((32'(ptr_q) + k) % REQ_COUNT);
      if (!found && req_valid_in[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
    pick_bytes = 3'(req_bytes_in >> (32'(pick) * 3));
    pick_data  = 40'(req_data_in >> (32'(pick) * 40));

    unique case (state_q)
      IDLE: begin
        // The ready cycle blocks a new accept: the granted requester still shows valid at the next edge.
        if (found && (ready_q == '0)) begin
          ready_d[pick] = 1'b1;
          ptr_d         = (32'(pick) == REQ_COUNT - 1) ? '0 : pick + 1'b1;
          if ((pick_bytes == 3'd0) || (pick_bytes > 3'd5)) begin
            err_d = 1'b1;
          end else begin
            trig_d     = 1'b1;
            tx_data_d  = pick_data;
            tx_bytes_d = pick_bytes;
            win_d      = pick;
            cnt_d      = '0;
            state_d    = WAIT_BUSY;
          end
        end
      end
      WAIT_BUSY: begin
        if (tx_busy_in) begin
          state_d = WAIT_DONE;
`ifdef PICC_TX_TIMEOUT_EN
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          err_d = 1'b1;
          if (GUARD_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GUARD;
            cnt_d   = CW'(GUARD_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_in) begin
          done_d[win_q] = 1'b1;
          if (GUARD_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GUARD;
            cnt_d   = CW'(GUARD_CYCLES - 1);
          end
        end
      end
      GUARD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_bytes_q <= '0;
      ready_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_bytes_q <= tx_bytes_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      trig_q     <= trig_d;
    end
  end

  assign req_ready_out    = ready_q;
  assign done_out         = done_q;
  assign err_out          = err_q;
  assign tx_data_out      = tx_data_q;
  assign tx_num_bytes_out = tx_bytes_q;
  assign tx_trigger_out   = trig_q;
  assign arb_busy_out     = (state_q != IDLE);

endmodule

// File: tb/tb_picc_tx_arbiter.sv
// Scoreboard bench for picc_tx_arbiter: a transaction-level model predicts every output event and its cycle.
module tb_picc_tx_arbiter;
  localparam int N  = 4;
  localparam int G  = 16;
  localparam int ST = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [40*N-1:0] req_data;
  logic [3*N-1:0]  req_bytes;
  logic [N-1:0]    req_ready_out, done_out;
  logic            err_out, tx_trigger_out, arb_busy_out;
  logic [39:0]     tx_data_out;
  logic [2:0]      tx_num_bytes_out;
  logic            busy;

  always #5 clk = ~clk;

  picc_tx_arbiter #(.REQ_COUNT(N), .GUARD_CYCLES(G), .START_TIMEOUT(ST)) dut (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid), .req_data_in(req_data), .req_bytes_in(req_bytes),
    .req_ready_out(req_ready_out), .done_out(done_out), .err_out(err_out),
    .tx_data_out(tx_data_out), .tx_num_bytes_out(tx_num_bytes_out),
    .tx_trigger_out(tx_trigger_out), .tx_busy_in(busy), .arb_busy_out(arb_busy_out)
  );

  typedef struct {
    int          cyc;
    logic [N-1:0] rdy;
    logic [N-1:0] dn;
    logic        err;
    logic        trig;
    logic        bsy;
    logic        chk;
    logic [39:0] data;
    logic [2:0]  nb;
  } ev_t;
  typedef struct { int dly; int len; } enc_t;

  ev_t  exp_q[$];
  enc_t enc_q[$];
  ev_t  mon_e;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int m_ptr, m_free, m_last;
  logic m_hung;

  logic [39:0] bt_data [N];
  logic [2:0]  bt_bytes[N];
  int          bt_dly  [N];
  int          bt_len  [N];

  int   on_at, off_at, enc_len;
  logic enc_active;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && ((req_ready_out != 0) || (done_out != 0) || err_out || tx_trigger_out)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d ready=%b done=%b err=%b trig=%b", cyc,
                 req_ready_out, done_out, err_out, tx_trigger_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (!(cyc == mon_e.cyc && req_ready_out == mon_e.rdy && done_out == mon_e.dn &&
              err_out == mon_e.err && tx_trigger_out == mon_e.trig && arb_busy_out == mon_e.bsy &&
              (!mon_e.chk || (tx_data_out == mon_e.data && tx_num_bytes_out == mon_e.nb)))) begin
          bad++;
          $display("FAIL event got cyc=%0d rdy=%b dn=%b err=%b trig=%b busy=%b data=%h nb=%0d required cyc=%0d rdy=%b dn=%b err=%b trig=%b busy=%b data=%h nb=%0d",
                   cyc, req_ready_out, done_out, err_out, tx_trigger_out, arb_busy_out, tx_data_out,
                   tx_num_bytes_out, mon_e.cyc, mon_e.rdy, mon_e.dn, mon_e.err, mon_e.trig, mon_e.bsy,
                   mon_e.data, mon_e.nb);
        end
      end
    end
  end

  task automatic check(input string name, input logic ok, input string detail);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s %s", name, detail);
    end
  endtask

  function automatic logic outputs_zero();
    return (req_ready_out == 0) && (done_out == 0) && !err_out && !tx_trigger_out &&
           (tx_data_out == 0) && (tx_num_bytes_out == 0) && !arb_busy_out;
  endfunction

  // Grants go to the first pending requester at or after the pointer; each frame frees the arbiter
  // G cycles after its done, a rejected request frees it after its ready cycle.
  task automatic plan(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    int t, r, w, d;
    ev_t e;
    pend   = mask;
    t      = (m_free > cyc) ? m_free : cyc;
    m_hung = 1'b0;
    m_last = t;
    while (pend != 0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      pend[w] = 1'b0;
      m_ptr   = (w + 1) % N;
      r       = t + 1;
      e.cyc = r; e.rdy = '0; e.rdy[w] = 1'b1; e.dn = '0;
      e.data = bt_data[w]; e.nb = bt_bytes[w];
      if (bt_bytes[w] == 0 || bt_bytes[w] > 5) begin
        e.err = 1'b1; e.trig = 1'b0; e.bsy = 1'b0; e.chk = 1'b0;
        exp_q.push_back(e);
        t = r + 1;
      end else begin
        e.err = 1'b0; e.trig = 1'b1; e.bsy = 1'b1; e.chk = 1'b1;
        exp_q.push_back(e);
        enc_q.push_back('{bt_dly[w], bt_len[w]});
        if (bt_len[w] == 0) begin
`ifdef PICC_TX_TIMEOUT_EN
          e.cyc = r + ST; e.rdy = '0; e.err = 1'b1; e.trig = 1'b0; e.bsy = (G > 0);
          exp_q.push_back(e);
          t = e.cyc + G;
`else
          m_hung = 1'b1;
          t = r;
`endif
        end else begin
          d = r + bt_dly[w] + bt_len[w] + 1;
          e.cyc = d; e.rdy = '0; e.dn[w] = 1'b1; e.trig = 1'b0; e.bsy = (G > 0);
          exp_q.push_back(e);
          t = d + G;
        end
      end
      m_last = e.cyc;
    end
    m_free = t;
  endtask

  // Requesters drop valid on their ready pulse; the encoder follows the planned delay/length per frame.
  task automatic drive_step();
    enc_t p;
    for (int i = 0; i < N; i++) if (req_ready_out[i]) req_valid[i] = 1'b0;
    if (tx_trigger_out) begin
      if (enc_q.size() > 0) p = enc_q.pop_front();
      else p = '{0, 1};
      on_at = cyc + p.dly; off_at = on_at + p.len; enc_len = p.len; enc_active = 1'b1;
    end
    if (enc_active && enc_len > 0 && cyc > off_at) enc_active = 1'b0;
    if (enc_active) busy = (enc_len > 0) && (cyc >= on_at) && (cyc < off_at);
    else            busy = ($urandom_range(0, 3) == 0);
  endtask

  task automatic run_batch(input logic [N-1:0] mask, input int keep);
    int limit;
    logic fin, timed;
    plan(mask);
    for (int i = 0; i < N; i++)
      if (mask[i]) begin
        req_data[i*40 +: 40] = bt_data[i];
        req_bytes[i*3 +: 3]  = bt_bytes[i];
      end
    req_valid = req_valid | mask;
    limit = ((m_last > m_free) ? m_last : m_free) + 40;
    fin = 1'b0; timed = 1'b0;
    while (!fin) begin
      @(negedge clk);
      drive_step();
      if (keep > 0) fin = (exp_q.size() <= keep);
      else          fin = (req_valid == 0) && (exp_q.size() == 0) && (cyc >= m_free);
      if (!fin && cyc > limit) begin
        total++; bad++;
        $display("FAIL batch_timeout cyc=%0d pending_events=%0d valid=%b", cyc, exp_q.size(), req_valid);
        req_valid = '0; exp_q.delete(); enc_q.delete();
        fin = 1'b1; timed = 1'b1;
      end
    end
    if (keep == 0 && !m_hung && !timed)
      check("idle_after_batch", !arb_busy_out, $sformatf("arb_busy got %b required 0", arb_busy_out));
  endtask

  task automatic set_req(input int i, input logic [39:0] d, input logic [2:0] b, input int dly, input int len);
    bt_data[i] = d; bt_bytes[i] = b; bt_dly[i] = dly; bt_len[i] = len;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_bytes = '0; busy = 1'b0;
    enc_active = 1'b0; on_at = 0; off_at = 0; enc_len = 0;
    for (int i = 0; i < N; i++) set_req(i, '0, 3'd1, 0, 1);
    repeat (3) @(negedge clk);
    check("reset_outputs", outputs_zero(), "outputs not all zero during reset");
    rst = 1'b0; m_free = cyc; m_ptr = 0;

    set_req(1, 40'h0024906735, 3'd4, 1, 10);
    run_batch(4'b0010, 0);

    for (int i = 0; i < N; i++) set_req(i, {8'(i), 32'($urandom)}, 3'(i + 1), $urandom_range(0, 3), $urandom_range(1, 6));
    run_batch(4'b1111, 0);
    run_batch(4'b0001, 0);

    set_req(2, 40'h1122334455, 3'd0, 0, 1);
    run_batch(4'b0100, 0);
    set_req(2, 40'h1122334455, 3'd6, 0, 1);
    run_batch(4'b0100, 0);

    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < N; i++)
        set_req(i, {8'($urandom), 32'($urandom)}, 3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(1, 8));
      run_batch(4'($urandom_range(1, 15)), 0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    set_req(2, 40'hA5A5A5A5A5, 3'd3, 0, 30);
    run_batch(4'b0100, 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1 check("reset_mid_frame", outputs_zero(), "outputs not all zero after mid-frame reset");
    exp_q.delete(); enc_q.delete(); enc_active = 1'b0; busy = 1'b0; req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; m_free = cyc; m_ptr = 0;
    for (int i = 0; i < N; i++) set_req(i, {8'($urandom), 32'($urandom)}, 3'd5, 0, 2);
    run_batch(4'b1111, 0);

    set_req(0, 40'h0102030405, 3'd2, 0, 0);
    run_batch(4'b0001, 0);
`ifndef PICC_TX_TIMEOUT_EN
    repeat (100) @(negedge clk);
    check("no_timeout_hold", arb_busy_out, $sformatf("arb_busy got %b required 1", arb_busy_out));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/picc_tx_arbiter.md
PICC_TX_ARBITER -- requirements
Module: picc_tx_arbiter

Interface
REQ-001 SHALL have parameter REQ_COUNT, default 4, number of response requesters sharing one PICC-to-PCD encoder.
REQ-002 SHALL have parameter GUARD_CYCLES, default 16, clk_in cycles of enforced idle between consecutive frames.
REQ-003 SHALL have parameter START_TIMEOUT, default 64, maximum clk_in cycles from trigger to encoder busy.
REQ-004 SHALL have port clk_in  input  1  system clock; single clock domain.
REQ-005 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid_in  input  REQ_COUNT  per-requester frame request; held until accepted.
REQ-007 SHALL have port req_data_in  input  40*REQ_COUNT  frame payload; slice i = bits [40i+39:40i].
REQ-008 SHALL have port req_bytes_in  input  3*REQ_COUNT  payload byte count; slice i = bits [3i+2:3i].
REQ-009 SHALL have port req_ready_out  output  REQ_COUNT  one-hot, one-cycle accept pulse.
REQ-010 SHALL have port done_out  output  REQ_COUNT  one-hot, one-cycle frame-complete pulse.
REQ-011 SHALL have port err_out  output  1  one-cycle pulse on rejected request or start timeout.
REQ-012 SHALL have port tx_data_out  output  40  payload to encoder.
REQ-013 SHALL have port tx_num_bytes_out  output  3  byte count to encoder.
REQ-014 SHALL have port tx_trigger_out  output  1  one-cycle encoder start pulse.
REQ-015 SHALL have port tx_busy_in  input  1  encoder busy; high while a frame is transmitted.
REQ-016 SHALL have port arb_busy_out  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, WAIT_BUSY, WAIT_DONE, GUARD.
REQ-018 In IDLE with any req_valid_in bit set at a clock edge, SHALL select a winner round-robin, starting from the index after the last grant (index 0 first after reset).
REQ-019 On acceptance SHALL, in the following cycle, assert req_ready_out[winner] and tx_trigger_out for exactly one cycle, drive latched data/bytes on tx_data_out/tx_num_bytes_out, and enter WAIT_BUSY.
REQ-020 tx_data_out and tx_num_bytes_out SHALL remain stable from the trigger cycle until return to IDLE.
REQ-021 A request with byte count 0 or greater than 5 SHALL be accepted (ready pulse), produce no trigger and no done, pulse err_out in the ready cycle, advance the round-robin pointer, and return to IDLE.
REQ-022 WAIT_BUSY SHALL go to WAIT_DONE when tx_busy_in=1.
REQ-023 WAIT_DONE SHALL, on tx_busy_in=0, pulse done_out[winner] for one cycle and enter GUARD (or IDLE directly if GUARD_CYCLES=0).
REQ-024 GUARD SHALL last exactly GUARD_CYCLES cycles, ignore req_valid_in, then enter IDLE.
REQ-025 Requests asserted while not in IDLE SHALL be held pending and never dropped; at most one accept per IDLE visit.
REQ-026 A requester deasserting valid before accept SHALL simply not be granted; no error.
REQ-027 tx_busy_in activity while in IDLE or GUARD SHALL be ignored.

Reset
REQ-028 Asserting rst_in SHALL immediately force state IDLE, all outputs 0, round-robin pointer to index 0, and counters to 0, including mid-frame.
REQ-029 After reset release, the first accept SHALL occur no earlier than the first clock edge with rst_in low.

Configuration
REQ-030 With macro PICC_TX_TIMEOUT_EN defined, WAIT_BUSY SHALL count cycles and, if tx_busy_in stays 0 for START_TIMEOUT cycles, pulse err_out, suppress done_out, and enter GUARD.
REQ-031 Without PICC_TX_TIMEOUT_EN, WAIT_BUSY SHALL wait indefinitely and no timeout logic SHALL exist.

Verification
REQ-032 Req1 valid, data 0x0024906735, bytes 4 -> next cycle ready_out=0010, trigger=1, tx_data=0x0024906735; busy 1 for 10 cycles then 0 -> done_out=0010 one cycle.
REQ-033 Req0..3 all valid continuously -> grants in order 0,1,2,3,0, each separated by at least GUARD_CYCLES=16 idle cycles after done.
REQ-034 Req2 with bytes 0, then with bytes 6 -> ready_out=0100 and err_out=1 each time, trigger never asserted.
REQ-035 rst_in asserted during WAIT_DONE -> all outputs 0 same cycle, no done pulse; after release req0 granted first.
REQ-036 With PICC_TX_TIMEOUT_EN, busy held 0 after trigger -> err_out pulse exactly 64 cycles after trigger, no done, GUARD then IDLE; without the macro, arb_busy_out stays 1.
